lcd_frame_writer: RTL and testbench
===================================

# lcd_frame_writer

Downstream consumer of the pixel processing unit: takes the 2-bit pixel stream plus HBlank/VBlank flags and writes it into a framebuffer BRAM for the video output path. It tracks screen X/Y itself, packs four pixels per byte, and detects malformed lines. With double-buffering compiled in, it also flips a bank select once per frame so the display side never reads a half-written frame.

## Interface
Parameters:
- H_PIXELS, 160, visible pixels per line
- V_LINES, 144, visible lines per frame
- PIX_PER_WORD, 4, 2-bit pixels packed per framebuffer byte (fixed at 4; other values unsupported)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- pixel_in  input  2  shade index from the PPU
- pixel_valid_in  input  1  pixel_in valid this clk_in cycle (single-cycle strobes)
- hblank_in  input  1  PPU HBlank level
- vblank_in  input  1  PPU VBlank level
- fb_addr_out  output  FB_AW  byte address; FB_AW = 14 with double-buffering, 13 without
- fb_data_out  output  8  packed byte
- fb_we_out  output  1  write strobe, one cycle per byte
- fb_read_sel_out  output  1  bank the display may read
- frame_done_out  output  1  one-cycle pulse when a frame is complete
- line_error_out  output  1  sticky: malformed line or frame seen

## Operation
- Reset values: all outputs 0. Internal state: x=0, y=0, write bank=0, state SYNC.
- States:
  - SYNC: ignore pixels. On rising vblank_in, go to VBLANK. Recovers from a reset in mid-frame.
  - VBLANK: on falling vblank_in, set x=0, y=0, go to ACTIVE.
  - ACTIVE: accept pixels. On rising hblank_in, go to HBL.
  - HBL: on falling hblank_in, go to ACTIVE. On rising vblank_in, go to VBLANK.
- Edge detection uses one registered copy of hblank_in and vblank_in.
- Pixel accept: pixel_valid_in && state==ACTIVE && x<H_PIXELS.
  - Accepted pixel goes to bits [2*(x%4)+1 : 2*(x%4)] of the pack register, then x increments.
  - On the accepted pixel with x%4==3, issue a write:
    - fb_addr_out = wbank*5760 + y*40 + x/4
    - fb_data_out = completed byte
  - Address arithmetic is done at FB_AW width; y*40 uses shift-add, (y<<5)+(y<<3).
- Overflow: a valid pixel in ACTIVE with x==H_PIXELS is dropped and sets line_error_out.
- Line end, on rising hblank_in:
  - If x!=H_PIXELS, set line_error_out. A partial pack is discarded, not written.
  - Set x=0 and y=y+1.
  - Writes may only occur for y<V_LINES. Pixels arriving with y≥V_LINES are dropped and set line_error_out.
- Frame end, on rising vblank_in from HBL:
  - Pulse frame_done_out.
  - If y!=V_LINES, set line_error_out.
  - Double-buffer: fb_read_sel_out <= wbank; wbank <= ~wbank.
- Simultaneous rising hblank_in and vblank_in: the hblank edge is processed first, then the vblank edge, in the same cycle.
- line_error_out clears only on reset.

## Timing
- Write latency: fb_we_out is asserted the clk_in cycle after the 4th pixel of a byte is accepted (registered outputs).
- fb_we_out is never high two cycles in a row, because pixel strobes are at least one cycle apart.
- frame_done_out and the fb_read_sel_out flip occur one cycle after the vblank edge is registered, i.e. two cycles after vblank_in rises.
- The final byte of line 143 is written before frame_done_out pulses.
- Asynchronous reset forces outputs to 0 immediately. Deassertion is synchronized externally.

## Configuration
- FB_DOUBLE_BUFFER_EN defined: two banks of 5760 bytes, FB_AW=14, banks swap at every frame end.
- FB_DOUBLE_BUFFER_EN undefined: one bank, FB_AW=13, wbank fixed at 0, fb_read_sel_out tied to 0, frame_done_out still pulses.

## Structure
- Shared package lcd_pkg holds:
  - H_PIXELS, V_LINES, BYTES_PER_LINE (40), BANK_BYTES (5760)
  - the state enum {SYNC, VBLANK, ACTIVE, HBL}
- One sub-module, fb_addr_gen: computes bank*BANK_BYTES + y*BYTES_PER_LINE + x/4 combinationally.
- Pixel packing and the FSM stay in the top module.

## Test plan
- Full frame, incrementing pattern (pixel = x%4) through SYNC→VBLANK→ACTIVE → 5760 writes, every byte 0xE4, addresses 0..5759, frame_done_out one pulse, line_error_out 0.
- Second frame (double-buffer build) → writes at 5760..11519; fb_read_sel_out goes 0→1 at first frame end and 1→0 at second.
- Line with 161 pixels → 40 writes for that line, 161st pixel dropped, line_error_out=1, next line starts at y*40 correctly.
- Line with 158 pixels → 39 writes, no partial write, line_error_out=1.
- Reset asserted at y=70 → outputs 0 at once; no writes until a full vblank rise/fall; next frame writes start at address 0 of bank 0.
- Pixel strobes during HBlank/VBlank → no fb_we_out, x unchanged, line_error_out stays 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and state type for the LCD framebuffer writer.
// FB_DOUBLE_BUFFER_EN selects a two-bank framebuffer (14-bit addresses) instead of one (13-bit).
package lcd_pkg;

  localparam int H_PIXELS       = 160;
  localparam int V_LINES        = 144;
  localparam int PIX_PER_WORD   = 4;
  localparam int BYTES_PER_LINE = H_PIXELS / PIX_PER_WORD;
  localparam int BANK_BYTES     = BYTES_PER_LINE * V_LINES;

`ifdef FB_DOUBLE_BUFFER_EN
  localparam int FB_AW = 14;
`else
  localparam int FB_AW = 13;
`endif

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2,
    HBL    = 2'd3
  } fw_state_t;

endpackage

// File: rtl/lcd_frame_writer_if.sv
// Pixel-stream and framebuffer-write bundle between the PPU side and the frame writer.
interface lcd_frame_writer_if;
  import lcd_pkg::*;

  logic [1:0]       pixel_in;
  logic             pixel_valid_in;
  logic             hblank_in;
  logic             vblank_in;
  logic [FB_AW-1:0] fb_addr_out;
  logic [7:0]       fb_data_out;
  logic             fb_we_out;
  logic             fb_read_sel_out;
  logic             frame_done_out;
  logic             line_error_out;

  // PPU / test side: drives the stream, observes the framebuffer port
  modport master (
    output pixel_in, pixel_valid_in, hblank_in, vblank_in,
    input  fb_addr_out, fb_data_out, fb_we_out, fb_read_sel_out,
           frame_done_out, line_error_out
  );

  modport slave (
    input  pixel_in, pixel_valid_in, hblank_in, vblank_in,
    output fb_addr_out, fb_data_out, fb_we_out, fb_read_sel_out,
           frame_done_out, line_error_out
  );

endinterface

// File: rtl/lcd_frame_writer_addr_gen.sv
// Framebuffer byte address: bank*BANK_BYTES + y*BYTES_PER_LINE + word, all at FB_AW width.
module fb_addr_gen
  import lcd_pkg::*;
(
  input  logic             bank,
  input  logic [7:0]       y,
  input  logic [5:0]       word,
  output logic [FB_AW-1:0] addr
);

  logic [FB_AW-1:0] y_w;
  logic [FB_AW-1:0] bank_off;

  // y*40 as (y<<5)+(y<<3) keeps this a pair of adders rather than a multiplier
  always_comb begin
    y_w      = FB_AW'(y);
    bank_off = bank ? FB_AW'(BANK_BYTES) : '0;
    addr     = bank_off + (y_w << 5) + (y_w << 3) + FB_AW'(word);
  end

endmodule

// File: rtl/lcd_frame_writer.sv
// Packs the PPU's 2-bit pixel stream four-per-byte into the framebuffer, tracking X/Y from
// the blank flags. Define FB_DOUBLE_BUFFER_EN for two banks that swap at each frame end.
//
// state  | meaning
// -------+--------------------------------------------------------------
// SYNC   | after reset; pixels ignored until the next VBlank rise
// VBLANK | in vertical blank; falling VBlank restarts at x=0, y=0
// ACTIVE | visible part of a line; pixels accepted and packed
// HBL    | horizontal blank; falling HBlank resumes, rising VBlank ends frame
module lcd_frame_writer #(
  parameter int H_PIXELS     = lcd_pkg::H_PIXELS,
  parameter int V_LINES      = lcd_pkg::V_LINES,
  parameter int PIX_PER_WORD = lcd_pkg::PIX_PER_WORD
) (
  input logic               clk_in,
  input logic               rst_in,
  lcd_frame_writer_if.slave bus
);
  import lcd_pkg::*;

  localparam logic [7:0] X_END     = 8'(H_PIXELS);
  localparam logic [7:0] Y_END     = 8'(V_LINES);
  localparam logic [7:0] PPW       = 8'(PIX_PER_WORD);
  localparam logic [7:0] LAST_SLOT = 8'(PIX_PER_WORD - 1);

  fw_state_t        state;
  logic [7:0]       x;
  logic [7:0]       y;
  logic [7:0]       y_inc;
  logic [7:0]       y_at_end;
  logic [5:0]       pack;
  logic [5:0]       word;
  logic             wbank;
  logic             hb_q;
  logic             vb_q;
  logic             hb_rise;
  logic             hb_fall;
  logic             vb_rise;
  logic             vb_fall;
  logic             frame_end;
  logic             pix_ok;
  logic             slot_last;
  logic [FB_AW-1:0] addr_nxt;

  always_comb begin
    y_inc     = (y == 8'hFF) ? y : y + 8'd1;
    // when HBlank and VBlank rise together the line end is folded in first
    y_at_end  = (state == ACTIVE) ? y_inc : y;
    frame_end = vb_rise && ((state == HBL) || ((state == ACTIVE) && hb_rise));
    pix_ok    = (x < X_END) && (y < Y_END);
    word      = 6'(x / PPW);
    slot_last = ((x % PPW) == LAST_SLOT);
  end

  fb_addr_gen u_addr_gen (
    .bank (wbank),
    .y    (y),
    .word (word),
    .addr (addr_nxt)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hb_q    <= 1'b0;
      vb_q    <= 1'b0;
      hb_rise <= 1'b0;
      hb_fall <= 1'b0;
      vb_rise <= 1'b0;
      vb_fall <= 1'b0;
    end else begin
      hb_q    <= bus.hblank_in;
      vb_q    <= bus.vblank_in;
      hb_rise <= bus.hblank_in & ~hb_q;
      hb_fall <= ~bus.hblank_in & hb_q;
      vb_rise <= bus.vblank_in & ~vb_q;
      vb_fall <= ~bus.vblank_in & vb_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state              <= SYNC;
      x                  <= 8'd0;
      y                  <= 8'd0;
      pack               <= 6'd0;
      bus.fb_addr_out    <= '0;
      bus.fb_data_out    <= 8'd0;
      bus.fb_we_out      <= 1'b0;
      bus.frame_done_out <= 1'b0;
      bus.line_error_out <= 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
      wbank               <= 1'b0;
      bus.fb_read_sel_out <= 1'b0;
`endif
    end else begin
      bus.fb_we_out      <= 1'b0;
      bus.frame_done_out <= 1'b0;

      case (state)
        SYNC: begin
          if (vb_rise) state <= VBLANK;
        end

        VBLANK: begin
          if (vb_fall) begin
            x     <= 8'd0;
            y     <= 8'd0;
            state <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (hb_rise) begin
            // a partial pack is simply abandoned; the next line overwrites it
            if (x != X_END) bus.line_error_out <= 1'b1;
            x     <= 8'd0;
            y     <= y_inc;
            state <= HBL;
          end else if (bus.pixel_valid_in) begin
            if (!pix_ok) begin
              bus.line_error_out <= 1'b1;
            end else begin
              case (x[1:0])
                2'd0:    pack[1:0] <= bus.pixel_in;
                2'd1:    pack[3:2] <= bus.pixel_in;
                2'd2:    pack[5:4] <= bus.pixel_in;
                default: ;
              endcase
              if (slot_last) begin
                bus.fb_addr_out <= addr_nxt;
                bus.fb_data_out <= {bus.pixel_in, pack};
                bus.fb_we_out   <= 1'b1;
              end
              x <= x + 8'd1;
            end
          end
        end

        HBL: begin
          if (hb_fall) state <= ACTIVE;
        end

        default: state <= SYNC;
      endcase

      if (frame_end) begin
        state              <= VBLANK;
        bus.frame_done_out <= 1'b1;
        if (y_at_end != Y_END) bus.line_error_out <= 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
        // display moves to the bank just completed; writing continues in the other
        bus.fb_read_sel_out <= wbank;
        wbank               <= ~wbank;
`endif
      end
    end
  end

`ifndef FB_DOUBLE_BUFFER_EN
  assign wbank               = 1'b0;
  assign bus.fb_read_sel_out = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Scoreboard bench for lcd_frame_writer: stimulus pushes expected framebuffer writes,
// a negedge monitor pops and compares every fb_we_out strobe.
module tb_lcd_frame_writer;
  import lcd_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  lcd_frame_writer_if bus ();

  lcd_frame_writer dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [7:0]       data;
  } wr_t;

  wr_t  sb_q[$];
  wr_t  mon_e;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   fd_count = 0;
  int   exp_fd   = 0;
  logic we_prev  = 1'b0;

  int        tb_x;
  int        tb_y;
  bit        tb_bank;
  bit        tb_live;
  bit        tb_hbl;
  bit        exp_err;
  bit        exp_sel;
  logic [5:0] tb_pack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (bus.fb_we_out) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write (t=%0t)",
                 bus.fb_addr_out, bus.fb_data_out, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wr_addr", 32'(bus.fb_addr_out), 32'(mon_e.addr));
        chk("wr_data", 32'(bus.fb_data_out), 32'(mon_e.data));
      end
      if (we_prev) chk("we_back_to_back", 32'(we_prev), 32'd0);
    end
    if (bus.frame_done_out) begin
      fd_count++;
      chk("bytes_before_frame_done", 32'(sb_q.size()), 32'd0);
    end
    we_prev = bus.fb_we_out;
  end

  initial begin
    #(10 * 150000);
    n_bad++;
    $display("FAIL watchdog: cycle budget exceeded, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  function automatic logic [1:0] pat(input int sel, input int i, input int yy);
    return (sel == 0) ? 2'(i % 4) : 2'((i * 3 + yy) % 4);
  endfunction

  task automatic send_pixel(input logic [1:0] p);
    wr_t w;
    bus.pixel_in       = p;
    bus.pixel_valid_in = 1'b1;
    if (tb_live && !tb_hbl) begin
      if (tb_x < H_PIXELS && tb_y < V_LINES) begin
        if (tb_x % 4 == 3) begin
          w.addr = FB_AW'(tb_bank * BANK_BYTES + tb_y * BYTES_PER_LINE + tb_x / 4);
          w.data = {p, tb_pack};
          sb_q.push_back(w);
        end else begin
          tb_pack[2 * (tb_x % 4) +: 2] = p;
        end
        tb_x++;
      end else begin
        exp_err = 1'b1;
      end
    end
    tick();
    bus.pixel_valid_in = 1'b0;
    tick();
  endtask

  // pixels of one line followed by the HBlank rise; leaves hblank high
  task automatic send_line(input int n, input int sel);
    for (int i = 0; i < n; i++) send_pixel(pat(sel, i, tb_y));
    bus.hblank_in = 1'b1;
    if (tb_live && !tb_hbl) begin
      if (tb_x != H_PIXELS) exp_err = 1'b1;
      tb_x   = 0;
      tb_y++;
      tb_hbl = 1'b1;
    end
    tick(3);
  endtask

  task automatic hbl_end();
    bus.hblank_in = 1'b0;
    tb_hbl        = 1'b0;
    tick(3);
  endtask

  task automatic frame_start(input int strobes);
    bus.vblank_in = 1'b1;
    tick(3);
    for (int i = 0; i < strobes; i++) send_pixel(2'd1);
    bus.vblank_in = 1'b0;
    tick(3);
    tb_live = 1'b1;
    tb_hbl  = 1'b0;
    tb_x    = 0;
    tb_y    = 0;
  endtask

  task automatic frame_end();
    bus.vblank_in = 1'b1;
    if (tb_live) begin
      exp_fd++;
      if (tb_y != V_LINES) exp_err = 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
      exp_sel = tb_bank;
      tb_bank = ~tb_bank;
`endif
    end
    tb_live = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("frame_done_early", 32'(bus.frame_done_out), 32'd0);
    @(posedge clk_in);
    @(negedge clk_in);
    chk("frame_done_pulse", 32'(bus.frame_done_out), 32'd1);
    chk("read_sel", 32'(bus.fb_read_sel_out), 32'(exp_sel));
    @(posedge clk_in);
    @(negedge clk_in);
    chk("frame_done_width", 32'(bus.frame_done_out), 32'd0);
    @(posedge clk_in);
    #2;
    bus.hblank_in = 1'b0;
    tb_hbl        = 1'b0;
    tick(2);
    chk("frame_done_count", 32'(fd_count), 32'(exp_fd));
    chk("frame_err", 32'(bus.line_error_out), 32'(exp_err));
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_addr"}, 32'(bus.fb_addr_out), 32'd0);
    chk({tag, "_data"}, 32'(bus.fb_data_out), 32'd0);
    chk({tag, "_we"}, 32'(bus.fb_we_out), 32'd0);
    chk({tag, "_sel"}, 32'(bus.fb_read_sel_out), 32'd0);
    chk({tag, "_fd"}, 32'(bus.frame_done_out), 32'd0);
    chk({tag, "_err"}, 32'(bus.line_error_out), 32'd0);
  endtask

  initial begin
    bus.pixel_in       = 2'd0;
    bus.pixel_valid_in = 1'b0;
    bus.hblank_in      = 1'b0;
    bus.vblank_in      = 1'b0;
    tb_x = 0; tb_y = 0; tb_bank = 1'b0; tb_live = 1'b0; tb_hbl = 1'b0;
    exp_err = 1'b0; exp_sel = 1'b0; tb_pack = 6'd0;

    #1;
    check_outputs_zero("reset");
    tick(3);
    rst_in = 1'b1;
    tick(3);

    // frame 1: clean full frame, bank 0, with strobes in VBlank and in one HBlank
    send_pixel(2'd2);
    frame_start(3);
    for (int l = 0; l < V_LINES; l++) begin
      send_line(H_PIXELS, 0);
      if (l == 10) begin
        for (int k = 0; k < 3; k++) send_pixel(2'd3);
      end
      if (l != V_LINES - 1) hbl_end();
    end
    frame_end();
    chk("frame1_err_clear", 32'(bus.line_error_out), 32'd0);

    // frame 2: malformed lines in the other bank
    frame_start(0);
    for (int i = 0; i < H_PIXELS + 1; i++) send_pixel(pat(1, i, tb_y));
    chk("overflow_err", 32'(bus.line_error_out), 32'd1);
    send_line(0, 1);
    hbl_end();
    send_line(H_PIXELS, 1);
    hbl_end();
    send_line(H_PIXELS - 2, 1);
    hbl_end();
    send_line(H_PIXELS, 1);
    frame_end();

    // frame 3: single line, then frame 4 is interrupted by reset at y=70
    frame_start(0);
    send_line(H_PIXELS, 0);
    frame_end();
    frame_start(0);
    for (int l = 0; l < 70; l++) begin
      send_line(H_PIXELS, 1);
      hbl_end();
    end
    chk("sb_empty_before_reset", 32'(sb_q.size()), 32'd0);
    rst_in = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    tb_live = 1'b0; tb_hbl = 1'b0; tb_bank = 1'b0; exp_err = 1'b0; exp_sel = 1'b0;
    tick(3);
    rst_in = 1'b1;
    tick(2);

    // still in SYNC: a whole line is ignored until a VBlank rise/fall
    send_line(H_PIXELS, 0);
    hbl_end();
    frame_start(0);
    send_line(H_PIXELS, 0);
    chk("post_reset_err", 32'(bus.line_error_out), 32'd0);
    hbl_end();
    send_line(H_PIXELS - 2, 0);
    chk("short_line_err", 32'(bus.line_error_out), 32'd1);
    hbl_end();
    send_line(H_PIXELS, 1);
    hbl_end();
    tick(5);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
